// File: rtl/gumnut_ctrl.sv
// Gumnut core sequencing controller: fetch/decode/execute FSM with bus handshakes,
// PC and register-file control, and single-level interrupt entry gated by ie.
module gumnut_ctrl (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] op_i,
    input  logic [2:0] func_i,
    input  logic       z_i,
    input  logic       c_i,
    input  logic       inst_ack_i,
    input  logic       data_ack_i,
    input  logic       int_req_i,
    output logic       inst_cyc_o,
    output logic       inst_stb_o,
    output logic       ir_we_o,
    output logic       data_cyc_o,
    output logic       data_stb_o,
    output logic       data_we_o,
    output logic       port_sel_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic       pc_push_o,
    output logic       pc_pop_o,
    output logic       rf_we_o,
    output logic       cc_we_o,
    output logic       int_ack_o,
    output logic [2:0] state_o
);

    // state     | meaning
    // FETCH     | instruction bus cycle, wait for inst_ack_i
    // DECODE    | one idle cycle while the IR settles
    // EXECUTE   | ALU flags, branch/return PC control, or launch a data access
    // MEM       | data/port bus cycle, wait for data_ack_i
    // WRITEBACK | register-file write
    // INT       | push PC, load vector, clear ie
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_INT       = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   ie_q, ie_d;
    state_t boundary_st;
    logic   taken;

    // Every return to FETCH is an instruction boundary where a pending interrupt may enter.
    assign boundary_st = (int_req_i && ie_q) ? ST_INT : ST_FETCH;

    always_comb begin
        taken = 1'b0;
        case (func_i)
            3'b000, 3'b001: taken = 1'b1;
            3'b010:         taken = z_i;
            3'b011:         taken = ~z_i;
            3'b100:         taken = c_i;
            3'b101:         taken = ~c_i;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        inst_cyc_o = 1'b0;
        inst_stb_o = 1'b0;
        ir_we_o    = 1'b0;
        data_cyc_o = 1'b0;
        data_stb_o = 1'b0;
        data_we_o  = 1'b0;
        port_sel_o = 1'b0;
        pc_inc_o   = 1'b0;
        pc_load_o  = 1'b0;
        pc_push_o  = 1'b0;
        pc_pop_o   = 1'b0;
        rf_we_o    = 1'b0;
        cc_we_o    = 1'b0;
        int_ack_o  = 1'b0;
        // Outputs are forced quiet while reset is held, independent of the clock.
        if (rst_ni) begin
            case (state_q)
                ST_FETCH: begin
                    inst_cyc_o = 1'b1;
                    inst_stb_o = 1'b1;
                    if (inst_ack_i) begin
                        ir_we_o  = 1'b1;
                        pc_inc_o = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: state_d = ST_EXECUTE;
                ST_EXECUTE: begin
                    if (!(op_i[2] && op_i[1])) begin
                        cc_we_o = 1'b1;
                        state_d = ST_WRITEBACK;
                    end else if (!op_i[0]) begin
                        state_d = ST_MEM;
                    end else begin
                        if (func_i[2:1] == 2'b11) begin
                            pc_pop_o = 1'b1;
                            if (func_i[0]) ie_d = 1'b1;
                        end else if (taken) begin
                            pc_load_o = 1'b1;
                            pc_push_o = (func_i == 3'b001);
                        end
                        state_d = boundary_st;
                    end
                end
                ST_MEM: begin
                    data_cyc_o = 1'b1;
                    data_stb_o = 1'b1;
                    data_we_o  = func_i[0];
                    port_sel_o = func_i[1];
                    if (data_ack_i) state_d = func_i[0] ? boundary_st : ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    rf_we_o = 1'b1;
                    state_d = boundary_st;
                end
                ST_INT: begin
                    int_ack_o = 1'b1;
                    pc_push_o = 1'b1;
                    pc_load_o = 1'b1;
                    ie_d      = 1'b0;
                    state_d   = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FETCH;
            ie_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_gumnut_ctrl.sv
// Directed bench for gumnut_ctrl: table of instruction vectors plus hand-written
// sequences for wait states, interrupts and mid-access reset.
module tb_gumnut_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] op_i = 3'd0;
    logic [2:0] func_i = 3'd0;
    logic       z_i = 1'b0, c_i = 1'b0;
    logic       inst_ack_i = 1'b0, data_ack_i = 1'b0, int_req_i = 1'b0;
    logic       inst_cyc_o, inst_stb_o, ir_we_o;
    logic       data_cyc_o, data_stb_o, data_we_o, port_sel_o;
    logic       pc_inc_o, pc_load_o, pc_push_o, pc_pop_o;
    logic       rf_we_o, cc_we_o, int_ack_o;
    logic [2:0] state_o;

    gumnut_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .func_i(func_i),
        .z_i(z_i), .c_i(c_i), .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i),
        .int_req_i(int_req_i), .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
        .ir_we_o(ir_we_o), .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o),
        .data_we_o(data_we_o), .port_sel_o(port_sel_o), .pc_inc_o(pc_inc_o),
        .pc_load_o(pc_load_o), .pc_push_o(pc_push_o), .pc_pop_o(pc_pop_o),
        .rf_we_o(rf_we_o), .cc_we_o(cc_we_o), .int_ack_o(int_ack_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    typedef struct {
        string      name;
        logic [2:0] op, func;
        logic       z, c;
        logic       cc, ld, push, pop;
        logic       mem, we, psel, wb;
    } vec_t;

    vec_t vecs[16];

    // Entered just after a negedge with the FSM in FETCH; leaves it in FETCH.
    task automatic run_vec(input vec_t v);
        op_i = v.op; func_i = v.func; z_i = v.z; c_i = v.c; inst_ack_i = 1'b1;
        #1;
        chk({v.name, " fetch"}, {state_o, ir_we_o, pc_inc_o, inst_stb_o, inst_cyc_o}, 8'h0F);
        tick();
        inst_ack_i = 1'b0;
        #1;
        chk({v.name, " decode"}, {state_o, inst_stb_o, data_stb_o, ir_we_o, pc_inc_o, cc_we_o},
            {3'd1, 5'b0});
        tick();
        #1;
        chk({v.name, " execute"}, {state_o, cc_we_o, pc_load_o, pc_push_o, pc_pop_o, data_stb_o},
            {3'd2, v.cc, v.ld, v.push, v.pop, 1'b0});
        tick();
        if (v.mem) begin
            data_ack_i = 1'b1;
            #1;
            chk({v.name, " mem"}, {state_o, data_cyc_o, data_stb_o, data_we_o, port_sel_o, rf_we_o},
                {3'd3, 1'b1, 1'b1, v.we, v.psel, 1'b0});
            tick();
            data_ack_i = 1'b0;
        end
        if (v.wb) begin
            #1;
            chk({v.name, " writeback"}, {state_o, rf_we_o}, {3'd4, 1'b1});
            tick();
        end
        #1;
        chk({v.name, " back to fetch"}, {state_o, rf_we_o, inst_stb_o}, {3'd0, 1'b0, 1'b1});
    endtask

    // ALU-immediate from FETCH up to the boundary state after WRITEBACK.
    task automatic alu_to_boundary(input string tag, input logic [2:0] exp_st);
        op_i = 3'b000; func_i = 3'b000; inst_ack_i = 1'b1;
        tick(); inst_ack_i = 1'b0;
        tick(); tick();
        #1; chk({tag, " wb"}, {5'b0, state_o}, 8'd4);
        tick();
        #1; chk({tag, " after wb"}, {4'b0, state_o, int_ack_o}, {4'b0, exp_st, exp_st == 3'd5});
    endtask

    task automatic reti_instr(input string tag);
        op_i = 3'b111; func_i = 3'b111; inst_ack_i = 1'b1;
        tick(); inst_ack_i = 1'b0;
        tick();
        #1; chk({tag, " exec"}, {state_o, pc_pop_o, pc_load_o, pc_inc_o}, {3'd2, 3'b100});
        tick();
        #1; chk({tag, " after"}, {5'b0, state_o}, 8'd0);
    endtask

    // Structural invariants checked every cycle outside reset.
    initial forever begin
        @(negedge clk_i); #3;
        if (rst_ni) begin
            chk("pc one-hot", {5'b0, pc_inc_o, pc_load_o, pc_pop_o} & {5'b0, ({pc_inc_o, pc_load_o, pc_pop_o} - 3'd1)}, 8'd0);
            chk("stb exclusive", {7'b0, inst_stb_o & data_stb_o}, 8'd0);
        end
    end

    initial begin
        vecs[0]  = '{"addi", 3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[1]  = '{"subi", 3'b011, 3'b101, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[2]  = '{"alureg", 3'b100, 3'b010, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{"shift", 3'b101, 3'b001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[4]  = '{"ldm", 3'b110, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{"stm", 3'b110, 3'b001, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{"inp", 3'b110, 3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        vecs[7]  = '{"outp", 3'b110, 3'b011, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        vecs[8]  = '{"jmp", 3'b111, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{"jsb", 3'b111, 3'b001, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{"bz taken", 3'b111, 3'b010, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{"bz not", 3'b111, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{"bnz taken", 3'b111, 3'b011, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{"bc not", 3'b111, 3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{"bnc taken", 3'b111, 3'b101, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{"ret", 3'b111, 3'b110, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

        // Reset held: everything quiet, even in FETCH.
        #2;
        chk("reset outputs", {state_o, inst_cyc_o, inst_stb_o, data_stb_o, pc_inc_o, int_ack_o}, 8'h00);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("post-reset fetch", {5'b0, state_o}, 8'd0);
        chk("post-reset stb", {6'b0, inst_cyc_o, inst_stb_o}, 8'h03);

        foreach (vecs[i]) run_vec(vecs[i]);

        // ALU-immediate with two instruction wait states.
        begin
            logic [2:0] exp_st[7];
            exp_st = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
            op_i = 3'b001; func_i = 3'b000;
            for (int i = 0; i < 7; i++) begin
                inst_ack_i = (i == 2);
                #1;
                chk($sformatf("alu wait cyc%0d", i), {3'b0, state_o, cc_we_o, rf_we_o},
                    {3'b0, exp_st[i], i == 4, i == 5});
                tick();
            end
            inst_ack_i = 1'b0;
        end

        // ldm with data_ack_i three cycles late.
        op_i = 3'b110; func_i = 3'b000; inst_ack_i = 1'b1;
        tick(); inst_ack_i = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            data_ack_i = (i == 3);
            #1;
            chk($sformatf("ldm wait cyc%0d", i),
                {2'b0, state_o, data_stb_o, data_we_o, port_sel_o}, {2'b0, 3'd3, 3'b100});
            tick();
        end
        data_ack_i = 1'b0;
        #1; chk("ldm writeback", {4'b0, state_o, rf_we_o}, {4'b0, 3'd4, 1'b1});
        tick();

        // Interrupt entry, masking while ie=0, and reti re-enabling.
        int_req_i = 1'b1;
        alu_to_boundary("irq1", 3'd5);
        chk("int push/load", {5'b0, int_ack_o, pc_push_o, pc_load_o}, 8'h07);
        tick();
        #1; chk("int one cycle", {4'b0, state_o, int_ack_o}, 8'd0);
        alu_to_boundary("irq masked", 3'd0);
        reti_instr("reti");
        alu_to_boundary("irq2", 3'd5);
        int_req_i = 1'b0;
        tick();
        reti_instr("reti2");

        // Reset mid-MEM abandons the store.
        op_i = 3'b110; func_i = 3'b001; inst_ack_i = 1'b1;
        tick(); inst_ack_i = 1'b0;
        tick(); tick();
        #1; chk("stm in mem", {5'b0, state_o}, 8'd3);
        chk("stm strobe", {6'b0, data_cyc_o, data_stb_o}, 8'h03);
        #2; rst_ni = 1'b0;
        #1; chk("async reset", {state_o, data_cyc_o, data_stb_o, inst_stb_o, data_we_o, 1'b0}, 8'h00);
        tick(); tick();
        rst_ni = 1'b1;
        #1; chk("recover fetch", {5'b0, state_o, inst_stb_o, data_stb_o}, 8'h02);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
